// File: rtl/tb_sim_ctrl.sv
// tb_sim_ctrl -- simulation controller for the core testbenches.
//
// Watches per-channel pass / fail / exit indications, runs a cycle-limit
// watchdog, latches the first terminating cause, waits DRAIN_CYCLES and then
// raises a sticky done_o for the top level to act on.
//
// Optional feature: define TB_SIM_CTRL_HEARTBEAT_EN to add the heartbeat_i
// port and an idle watchdog (result IDLE_TIMEOUT after IDLE_LIMIT cycles
// without a heartbeat from any still-pending channel).
//
// Parameters:
//   NUM_CH       monitored channels (>= 1)
//   CNT_WIDTH    width of the cycle counter and max_cycles_i
//   DRAIN_CYCLES cycles from the terminating edge to done_o (0 allowed)
//   IDLE_LIMIT   heartbeat-idle threshold (heartbeat build only)
//
// Ports:
//   clk_i          clock
//   rst_i          synchronous active-high reset
//   enable_i       start monitoring (sampled in IDLE only)
//   max_cycles_i   cycle limit, 0 = unlimited
//   passed_i       per-channel pass indication
//   failed_i       per-channel fail indication
//   exit_valid_i   per-channel exit strobe
//   exit_value_i   per-channel exit code, channel c at [32c+31:32c]
//   heartbeat_i    per-channel activity pulse (heartbeat build only)
//   done_o         simulation finished (sticky until reset)
//   result_o       0 RUNNING 1 PASS 2 FAIL 3 EXIT_FAIL 4 TIMEOUT 5 IDLE_TIMEOUT
//   fail_ch_o      lowest channel causing FAIL / EXIT_FAIL, else 0
//   exit_value_o   exit code of fail_ch_o for EXIT_FAIL, else 0
//   cycle_cnt_o    RUN cycles elapsed (frozen after leaving RUN)
module tb_sim_ctrl #(
  parameter int NUM_CH       = 1,
  parameter int CNT_WIDTH    = 32,
  parameter int DRAIN_CYCLES = 16,
  parameter int IDLE_LIMIT   = 1000,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic [CNT_WIDTH-1:0] max_cycles_i,
  input  logic [NUM_CH-1:0]    passed_i,
  input  logic [NUM_CH-1:0]    failed_i,
  input  logic [NUM_CH-1:0]    exit_valid_i,
  input  logic [NUM_CH*32-1:0] exit_value_i,
`ifdef TB_SIM_CTRL_HEARTBEAT_EN
  input  logic [NUM_CH-1:0]    heartbeat_i,
`endif
  output logic                 done_o,
  output logic [2:0]           result_o,
  output logic [CH_W-1:0]      fail_ch_o,
  output logic [31:0]          exit_value_o,
  output logic [CNT_WIDTH-1:0] cycle_cnt_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  typedef enum logic [2:0] {
    RES_RUNNING      = 3'd0,
    RES_PASS         = 3'd1,
    RES_FAIL         = 3'd2,
    RES_EXIT_FAIL    = 3'd3,
    RES_TIMEOUT      = 3'd4,
    RES_IDLE_TIMEOUT = 3'd5
  } result_e;

  // The drain and idle counters share one width, large enough for either limit.
  localparam int AUX_MAX = (IDLE_LIMIT > DRAIN_CYCLES) ? IDLE_LIMIT : DRAIN_CYCLES;
  localparam int AUX_W   = (AUX_MAX > 0) ? $clog2(AUX_MAX + 1) : 1;

  state_e               state_q, state_d;
  result_e              cause;
  logic [NUM_CH-1:0]    ch_pass_q, ch_fail_q, pending;
  logic [NUM_CH-1:0]    fail_hit, exit_hit, pass_hit;
  logic [CH_W-1:0]      fail_idx, exit_idx;
  logic [31:0]          exit_sel;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic [AUX_W-1:0]     drain_cnt_q;
  logic                 timeout, idle_to, all_pass;
  logic                 in_run, leave_run, done_d;

  assign pending = ~(ch_pass_q | ch_fail_q);

  // Per-channel classification of this cycle's indications. Only pending
  // channels can change; fail beats exit-fail beats pass.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path
    // leaves it unassigned -- otherwise synthesis infers a latch.
    fail_hit = '0;
    exit_hit = '0;
    pass_hit = '0;
    fail_idx = '0;
    exit_idx = '0;
    exit_sel = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (pending[c]) begin
        fail_hit[c] = failed_i[c];
        exit_hit[c] = !failed_i[c] && exit_valid_i[c] && (exit_value_i[32*c +: 32] != 32'd0);
        pass_hit[c] = !failed_i[c] && !exit_hit[c] && (passed_i[c] || exit_valid_i[c]);
      end
    end
    // Descending scan so the lowest-index hit is the one that sticks.
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (fail_hit[c]) fail_idx = CH_W'(c);
      if (exit_hit[c]) begin
        exit_idx = CH_W'(c);
        exit_sel = exit_value_i[32*c +: 32];
      end
    end
  end

  // The counter value after this edge is what the limit is compared against,
  // so a limit of M fires on the edge that makes the count M.
  assign cnt_inc  = (&cycle_cnt_o) ? cycle_cnt_o : cycle_cnt_o + 1'b1;
  assign timeout  = (max_cycles_i != '0) && (cnt_inc >= max_cycles_i);
  assign all_pass = &(ch_pass_q | pass_hit);

`ifdef TB_SIM_CTRL_HEARTBEAT_EN
  logic [AUX_W-1:0] idle_cnt_q, idle_cnt_d;

  // Cleared by activity from a channel that has not finished; holds once no
  // channel is pending so finished cores cannot trip the watchdog.
  always_comb begin
    if (|(heartbeat_i & pending))  idle_cnt_d = '0;
    else if (!(|pending))          idle_cnt_d = idle_cnt_q;
    else                           idle_cnt_d = idle_cnt_q + 1'b1;
  end

  assign idle_to = (idle_cnt_d >= AUX_W'(IDLE_LIMIT));

  always_ff @(posedge clk_i) begin
    if (rst_i)        idle_cnt_q <= '0;
    else if (in_run)  idle_cnt_q <= idle_cnt_d;
  end
`else
  assign idle_to = 1'b0;
`endif

  always_comb begin
    if (|fail_hit)     cause = RES_FAIL;
    else if (|exit_hit) cause = RES_EXIT_FAIL;
    else if (idle_to)  cause = RES_IDLE_TIMEOUT;
    else if (timeout)  cause = RES_TIMEOUT;
    else if (all_pass) cause = RES_PASS;
    else               cause = RES_RUNNING;
  end

  // State register.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (enable_i) state_d = S_RUN;
      S_RUN:   if (cause != RES_RUNNING) state_d = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;
      S_DRAIN: if (drain_cnt_q == AUX_W'(DRAIN_CYCLES - 1)) state_d = S_DONE;
      default: state_d = S_DONE;
    endcase
  end

  // Output decode: load enables for the registered outputs.
  always_comb begin
    in_run    = (state_q == S_RUN);
    leave_run = in_run && (cause != RES_RUNNING);
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge clk_i) begin
    // NOTE: the reset is synchronous and clears every flop, channel status
    // included, so a reset from any state yields a completely fresh run.
    if (rst_i) begin
      done_o       <= 1'b0;
      result_o     <= RES_RUNNING;
      fail_ch_o    <= '0;
      exit_value_o <= '0;
      cycle_cnt_o  <= '0;
      ch_pass_q    <= '0;
      ch_fail_q    <= '0;
      drain_cnt_q  <= '0;
    end else begin
      done_o      <= done_d;
      drain_cnt_q <= (state_q == S_DRAIN) ? drain_cnt_q + 1'b1 : '0;
      if (in_run) begin
        cycle_cnt_o <= cnt_inc;
        ch_pass_q   <= ch_pass_q | pass_hit;
        ch_fail_q   <= ch_fail_q | fail_hit | exit_hit;
      end
      if (leave_run) begin
        result_o <= cause;
        case (cause)
          RES_FAIL: begin
            fail_ch_o    <= fail_idx;
            exit_value_o <= '0;
          end
          RES_EXIT_FAIL: begin
            fail_ch_o    <= exit_idx;
            exit_value_o <= exit_sel;
          end
          default: begin
            fail_ch_o    <= '0;
            exit_value_o <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tb_sim_ctrl.sv
// Bench for tb_sim_ctrl. Two instances share one stimulus bus:
//   A: NUM_CH=2, DRAIN_CYCLES=4, IDLE_LIMIT=50
//   B: NUM_CH=4, DRAIN_CYCLES=0, IDLE_LIMIT=1000
// A behavioural model derives, per test, the terminating edge and cause for
// each instance from the event list; a compare process then checks every
// output after every edge of the run. Edge 0 is the IDLE->RUN edge, edge k
// the one that makes the cycle count k.
module tb_tb_sim_ctrl;

  localparam int NA = 2, DA = 4, IA = 50;
  localparam int NB = 4, DB = 0, IB = 1000;
  localparam int CW = 32;
  localparam int NEVER = 32'h4000_0000;
`ifdef TB_SIM_CTRL_HEARTBEAT_EN
  localparam bit HB_EN = 1'b1;
`else
  localparam bit HB_EN = 1'b0;
`endif

  typedef enum int {EV_PASS, EV_FAIL, EV_EXIT} ev_kind_e;
  typedef struct {
    int          cyc;
    int          ch;
    ev_kind_e    kind;
    logic [31:0] val;
  } ev_t;
  typedef struct {
    int          n;
    int          res;
    int          ch;
    logic [31:0] val;
  } outcome_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic [CW-1:0] max_cycles = '0;
  logic [3:0]    passed = '0, failed = '0, exit_valid = '0;
  logic [127:0]  exit_value = '0;
`ifdef TB_SIM_CTRL_HEARTBEAT_EN
  logic [3:0]    heartbeat = '0;
`endif

  logic          done_a, done_b;
  logic [2:0]    res_a, res_b;
  logic [0:0]    fch_a;
  logic [1:0]    fch_b;
  logic [31:0]   exv_a, exv_b;
  logic [CW-1:0] cnt_a, cnt_b;

  always #5 clk = ~clk;

  tb_sim_ctrl #(.NUM_CH(NA), .CNT_WIDTH(CW), .DRAIN_CYCLES(DA), .IDLE_LIMIT(IA)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .max_cycles_i(max_cycles),
    .passed_i(passed[NA-1:0]), .failed_i(failed[NA-1:0]),
    .exit_valid_i(exit_valid[NA-1:0]), .exit_value_i(exit_value[NA*32-1:0]),
`ifdef TB_SIM_CTRL_HEARTBEAT_EN
    .heartbeat_i(heartbeat[NA-1:0]),
`endif
    .done_o(done_a), .result_o(res_a), .fail_ch_o(fch_a),
    .exit_value_o(exv_a), .cycle_cnt_o(cnt_a)
  );

  tb_sim_ctrl #(.NUM_CH(NB), .CNT_WIDTH(CW), .DRAIN_CYCLES(DB), .IDLE_LIMIT(IB)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .max_cycles_i(max_cycles),
    .passed_i(passed), .failed_i(failed),
    .exit_valid_i(exit_valid), .exit_value_i(exit_value),
`ifdef TB_SIM_CTRL_HEARTBEAT_EN
    .heartbeat_i(heartbeat),
`endif
    .done_o(done_b), .result_o(res_b), .fail_ch_o(fch_b),
    .exit_value_o(exv_b), .cycle_cnt_o(cnt_b)
  );

  int       n_cmp = 0;
  int       n_mis = 0;
  ev_t      ev_q[$];
  outcome_t exp_a, exp_b;
  bit       act = 1'b0;
  int       kc = 0;

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic void add_ev(int cyc, int ch, ev_kind_e kind, logic [31:0] val);
    ev_t e;
    e.cyc = cyc; e.ch = ch; e.kind = kind; e.val = val;
    ev_q.push_back(e);
  endfunction

  // Walks the run edge by edge with per-channel verdicts held in an array;
  // returns the first edge that ends the run and why.
  function automatic outcome_t model_run(int nch, int idle_lim, int maxc, int hb_stop, int horizon);
    outcome_t o;
    int st[4];          // 0 pending, 1 passed, 2 failed
    int last_hb;
    o.n = NEVER; o.res = 0; o.ch = 0; o.val = '0;
    for (int c = 0; c < 4; c++) st[c] = 0;
    last_hb = 0;
    for (int k = 1; k <= horizon; k++) begin
      bit any_pend, idle_to, to, all_pass, fl, pa, ex;
      int f_ch, e_ch;
      logic [31:0] e_val, v;
      any_pend = 1'b0;
      for (int c = 0; c < nch; c++) if (st[c] == 0) any_pend = 1'b1;
      if (k <= hb_stop && any_pend) last_hb = k;
      else if (!any_pend)           last_hb++;
      idle_to = HB_EN && ((k - last_hb) >= idle_lim);
      f_ch = -1; e_ch = -1; e_val = '0;
      for (int c = 0; c < nch; c++) begin
        if (st[c] == 0) begin
          fl = 1'b0; pa = 1'b0; ex = 1'b0; v = '0;
          foreach (ev_q[i]) begin
            if (ev_q[i].cyc == k && ev_q[i].ch == c) begin
              case (ev_q[i].kind)
                EV_PASS: pa = 1'b1;
                EV_FAIL: fl = 1'b1;
                default: begin ex = 1'b1; v = ev_q[i].val; end
              endcase
            end
          end
          if (fl) begin
            st[c] = 2;
            if (f_ch < 0) f_ch = c;
          end else if (ex && v != 0) begin
            st[c] = 2;
            if (e_ch < 0) begin e_ch = c; e_val = v; end
          end else if (pa || ex) begin
            st[c] = 1;
          end
        end
      end
      to = (maxc != 0) && (k >= maxc);
      all_pass = 1'b1;
      for (int c = 0; c < nch; c++) if (st[c] != 1) all_pass = 1'b0;
      if (f_ch >= 0)      begin o.res = 2; o.ch = f_ch; end
      else if (e_ch >= 0) begin o.res = 3; o.ch = e_ch; o.val = e_val; end
      else if (idle_to)   o.res = 5;
      else if (to)        o.res = 4;
      else if (all_pass)  o.res = 1;
      if (o.res != 0) begin
        o.n = k;
        return o;
      end
    end
    return o;
  endfunction

  task automatic cmp_dut(string tag, int k, outcome_t o, int d,
                         logic [31:0] done, logic [31:0] res, logic [31:0] fch,
                         logic [31:0] exv, logic [31:0] cnt);
    bit term;
    term = (k >= o.n);
    check({tag, " cycle_cnt"}, cnt, term ? 32'(o.n) : 32'(k));
    check({tag, " done"}, done, 32'(k >= o.n + d));
    check({tag, " result"}, res, term ? 32'(o.res) : 32'd0);
    check({tag, " fail_ch"}, fch, term ? 32'(o.ch) : 32'd0);
    check({tag, " exit_value"}, exv, term ? o.val : 32'd0);
  endtask

  // Compare process: 1 time unit after each active edge of a run.
  always @(posedge clk) begin
    #1;
    if (act) begin
      cmp_dut("A", kc, exp_a, DA, 32'(done_a), 32'(res_a), 32'(fch_a), exv_a, cnt_a);
      cmp_dut("B", kc, exp_b, DB, 32'(done_b), 32'(res_b), 32'(fch_b), exv_b, cnt_b);
      kc++;
    end
  end

  task automatic clear_inputs();
    passed = '0; failed = '0; exit_valid = '0; exit_value = '0;
`ifdef TB_SIM_CTRL_HEARTBEAT_EN
    heartbeat = '0;
`endif
  endtask

  task automatic drive(int k, int hb_stop);
    clear_inputs();
    foreach (ev_q[i]) begin
      if (ev_q[i].cyc == k) begin
        case (ev_q[i].kind)
          EV_PASS: passed[ev_q[i].ch] = 1'b1;
          EV_FAIL: failed[ev_q[i].ch] = 1'b1;
          default: begin
            exit_valid[ev_q[i].ch] = 1'b1;
            exit_value[ev_q[i].ch*32 +: 32] = ev_q[i].val;
          end
        endcase
      end
    end
`ifdef TB_SIM_CTRL_HEARTBEAT_EN
    heartbeat = (k <= hb_stop) ? 4'hF : 4'h0;
`else
    if (hb_stop < 0) passed = '0;
`endif
  endtask

  task automatic check_zero(string tag);
    check({tag, " A done"}, 32'(done_a), 32'd0);
    check({tag, " A result"}, 32'(res_a), 32'd0);
    check({tag, " A fail_ch"}, 32'(fch_a), 32'd0);
    check({tag, " A exit_value"}, exv_a, 32'd0);
    check({tag, " A cycle_cnt"}, cnt_a, 32'd0);
    check({tag, " B done"}, 32'(done_b), 32'd0);
    check({tag, " B result"}, 32'(res_b), 32'd0);
    check({tag, " B fail_ch"}, 32'(fch_b), 32'd0);
    check({tag, " B exit_value"}, exv_b, 32'd0);
    check({tag, " B cycle_cnt"}, cnt_b, 32'd0);
  endtask

  // Reset (from whatever state the previous test left), one idle cycle with
  // enable low, a one-cycle enable pulse, then `last` RUN-relative edges.
  task automatic run_test(string name, int maxc, int hb_stop, int limit, int stop_at);
    int last;
    exp_a = model_run(NA, IA, maxc, hb_stop, limit);
    exp_b = model_run(NB, IB, maxc, hb_stop, limit);
    last = ((exp_a.n + DA) > (exp_b.n + DB)) ? exp_a.n + DA : exp_b.n + DB;
    last += 3;
    if (last > limit) last = limit;
    if (stop_at > 0) last = stop_at;
    @(negedge clk);
    rst = 1'b1; enable = 1'b0; max_cycles = maxc; clear_inputs();
    @(negedge clk);
    rst = 1'b0;
    check_zero({name, " reset"});
    @(negedge clk);
    check_zero({name, " idle"});
    enable = 1'b1; kc = 0; act = 1'b1;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      enable = 1'b0;
      drive(k, hb_stop);
    end
    @(negedge clk);
    act = 1'b0;
    clear_inputs();
  endtask

  initial begin
    // All pass: ch0 passes at 10, ch1 exits 0 at 20.
    ev_q.delete();
    add_ev(10, 0, EV_PASS, 0); add_ev(20, 1, EV_EXIT, 0);
    run_test("all_pass", 0, NEVER, 40, 0);
    check("pin all_pass model n", 32'(exp_a.n), 32'd20);
    check("pin all_pass model res", 32'(exp_a.res), 32'd1);
    check("all_pass A result", 32'(res_a), 32'd1);
    check("all_pass A cycle_cnt", cnt_a, 32'd20);
    check("all_pass A done", 32'(done_a), 32'd1);
    check("all_pass B done", 32'(done_b), 32'd0);

    // Same run stopped in DRAIN, then in DONE; the next reset must clear it.
    run_test("drain_stop", 0, NEVER, 40, 22);
    check("drain_stop A done", 32'(done_a), 32'd0);
    check("drain_stop A result", 32'(res_a), 32'd1);
    run_test("done_stop", 0, NEVER, 40, 30);
    check("done_stop A done", 32'(done_a), 32'd1);

    // Exit-fail on ch2 and fail on ch3 together: plain FAIL wins.
    ev_q.delete();
    add_ev(5, 2, EV_EXIT, 32'h2A); add_ev(5, 3, EV_FAIL, 0);
    run_test("fail_exit", 0, NEVER, 20, 0);
    check("pin fail_exit model ch", 32'(exp_b.ch), 32'd3);
    check("fail_exit B result", 32'(res_b), 32'd2);
    check("fail_exit B fail_ch", 32'(fch_b), 32'd3);
    check("fail_exit B exit_value", exv_b, 32'd0);
    check("fail_exit B done", 32'(done_b), 32'd1);

    // Exit strobe alone: EXIT_FAIL with the exit code.
    ev_q.delete();
    add_ev(5, 2, EV_EXIT, 32'h2A); add_ev(7, 1, EV_EXIT, 32'h55);
    run_test("exit_only", 0, NEVER, 20, 0);
    check("exit_only B result", 32'(res_b), 32'd3);
    check("exit_only B fail_ch", 32'(fch_b), 32'd2);
    check("exit_only B exit_value", exv_b, 32'h2A);
    check("exit_only A result", 32'(res_a), 32'd3);
    check("exit_only A fail_ch", 32'(fch_a), 32'd1);
    check("exit_only A exit_value", exv_a, 32'h55);
    check("exit_only A cycle_cnt", cnt_a, 32'd7);

    // Timeout at 100, then no limit for 10000 cycles.
    ev_q.delete();
    run_test("timeout", 100, NEVER, 110, 0);
    check("pin timeout model n", 32'(exp_b.n), 32'd100);
    check("timeout A result", 32'(res_a), 32'd4);
    check("timeout A cycle_cnt", cnt_a, 32'd100);
    check("timeout B cycle_cnt", cnt_b, 32'd100);
    run_test("no_limit", 0, NEVER, 10000, 0);
    check("no_limit A done", 32'(done_a), 32'd0);
    check("no_limit B done", 32'(done_b), 32'd0);
    check("no_limit A cycle_cnt", cnt_a, 32'd10000);

    // Pass and fail on the same channel in the same cycle: FAIL.
    ev_q.delete();
    add_ev(6, 0, EV_PASS, 0); add_ev(6, 0, EV_FAIL, 0);
    run_test("same_cycle", 0, NEVER, 20, 0);
    check("same_cycle A result", 32'(res_a), 32'd2);
    check("same_cycle A fail_ch", 32'(fch_a), 32'd0);
    check("same_cycle B result", 32'(res_b), 32'd2);

    // A later fail on an already-passed channel is ignored.
    ev_q.delete();
    add_ev(5, 0, EV_PASS, 0); add_ev(8, 0, EV_FAIL, 0);
    add_ev(12, 1, EV_PASS, 0); add_ev(12, 2, EV_PASS, 0); add_ev(12, 3, EV_PASS, 0);
    run_test("pass_then_fail", 0, NEVER, 30, 0);
    check("pass_then_fail A result", 32'(res_a), 32'd1);
    check("pass_then_fail A cycle_cnt", cnt_a, 32'd12);
    check("pass_then_fail B result", 32'(res_b), 32'd1);

    // Several fails at once: lowest failing channel, exit code not reported.
    ev_q.delete();
    add_ev(9, 1, EV_FAIL, 0); add_ev(9, 3, EV_FAIL, 0); add_ev(9, 0, EV_EXIT, 32'h7);
    run_test("multi_fail", 0, NEVER, 20, 0);
    check("multi_fail B fail_ch", 32'(fch_b), 32'd1);
    check("multi_fail B exit_value", exv_b, 32'd0);
    check("multi_fail A fail_ch", 32'(fch_a), 32'd1);

    // Timeout beats an all-pass on the same edge; limit of 1.
    ev_q.delete();
    add_ev(15, 0, EV_PASS, 0); add_ev(15, 1, EV_PASS, 0);
    run_test("to_vs_pass", 15, NEVER, 30, 0);
    check("to_vs_pass A result", 32'(res_a), 32'd4);
    check("to_vs_pass A cycle_cnt", cnt_a, 32'd15);
    ev_q.delete();
    run_test("max_one", 1, NEVER, 10, 0);
    check("max_one B cycle_cnt", cnt_b, 32'd1);
    check("max_one B result", 32'(res_b), 32'd4);

`ifdef TB_SIM_CTRL_HEARTBEAT_EN
    // Heartbeats stop after cycle 30: idle timeout on A at 80.
    ev_q.delete();
    run_test("hb_idle", 0, 30, 120, 0);
    check("pin hb_idle model n", 32'(exp_a.n), 32'd80);
    check("hb_idle A result", 32'(res_a), 32'd5);
    check("hb_idle A cycle_cnt", cnt_a, 32'd80);
    check("hb_idle B done", 32'(done_b), 32'd0);
    // Timeout on the same edge: idle timeout wins on A, B times out.
    run_test("hb_vs_to", 80, 30, 120, 0);
    check("hb_vs_to A result", 32'(res_a), 32'd5);
    check("hb_vs_to B result", 32'(res_b), 32'd4);
`endif

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
